// File: rtl/switch_debounce.sv
// Debounces a raw mechanical switch: synchronizer chain, then a 4-state qualification FSM.
// Optional macro SWITCH_DEBOUNCE_TOGGLE_EN turns light into a per-press toggle (else light = level).
module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic switch,
  output logic level,
  output logic rise,
  output logic fall,
  output logic light
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign s = sync_q[SYNC_STAGES-1];

  // State register, synchronizer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= STABLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], switch};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next state: the counter only runs in WAIT states and is zero otherwise
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      STABLE_LOW: begin
        if (s) state_d = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (!s)                  state_d = STABLE_LOW;
        else if (cnt_q == CNT_MAX) state_d = STABLE_HIGH;
        else                     cnt_d   = cnt_q + CW'(1);
      end
      STABLE_HIGH: begin
        if (!s) state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (s)                   state_d = STABLE_HIGH;
        else if (cnt_q == CNT_MAX) state_d = STABLE_LOW;
        else                     cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = STABLE_LOW;
    endcase
  end

  // Outputs are computed from the upcoming state so they change on the qualifying edge
  always_comb begin
    level_d = (state_d == STABLE_HIGH) || (state_d == WAIT_LOW);
    rise_d  = (state_q == WAIT_HIGH) && (state_d == STABLE_HIGH);
    fall_d  = (state_q == WAIT_LOW)  && (state_d == STABLE_LOW);
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
  logic light_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) light_q <= 1'b0;
    else        light_q <= light_q ^ rise_q;
  end

  assign light = light_q;
`else
  assign light = level_q;
`endif

endmodule

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, number of consecutive stable synchronized samples required to accept a new switch level; legal range 2 or more.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of input synchronizer flops; legal range 2 or more.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port switch  input  1  raw, asynchronous, bouncing mechanical switch or button.
REQ-006 SHALL have port level  output  1  debounced switch level.
REQ-007 SHALL have port rise  output  1  one-cycle pulse when level goes 0->1.
REQ-008 SHALL have port fall  output  1  one-cycle pulse when level goes 1->0.
REQ-009 SHALL have port light  output  1  LED drive; behaviour set by REQ-025/REQ-026.

Function
REQ-010 SHALL pass switch through a SYNC_STAGES-deep flop chain; the last stage is the sampled signal s, and only s feeds the FSM.
REQ-011 SHALL implement FSM states STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW.
REQ-012 STABLE_LOW: s=1 -> WAIT_HIGH with count=0; otherwise stay.
REQ-013 WAIT_HIGH: s=0 -> STABLE_LOW with count=0 (bounce rejected, no pulse); s=1 with count=DEBOUNCE_CYCLES-1 -> STABLE_HIGH; otherwise count+1.
REQ-014 STABLE_HIGH and WAIT_LOW SHALL mirror REQ-012/REQ-013 with the polarity of s inverted.
REQ-015 The counter SHALL be clog2(DEBOUNCE_CYCLES) bits wide, SHALL never exceed DEBOUNCE_CYCLES-1, and SHALL hold 0 in both STABLE states.
REQ-016 level SHALL be registered: 1 in STABLE_HIGH and WAIT_LOW, 0 in STABLE_LOW and WAIT_HIGH.
REQ-017 rise SHALL be 1 for exactly the one cycle following the WAIT_HIGH->STABLE_HIGH transition; fall likewise for WAIT_LOW->STABLE_LOW; rise and fall SHALL never be 1 together.
REQ-018 Latency from a clean switch change (setup met before edge 1) to the level change SHALL be SYNC_STAGES+DEBOUNCE_CYCLES+1 rising edges.
REQ-019 Any opposite-level sample of s during a WAIT state SHALL restart qualification from count 0; level SHALL never glitch.
REQ-020 A switch pulse shorter than DEBOUNCE_CYCLES cycles at s SHALL produce no change on level, rise, fall or light.

Reset
REQ-021 While rst_n=0, all synchronizer flops SHALL be 0, state STABLE_LOW, count 0, level=0, rise=0, fall=0, light=0, asynchronously.
REQ-022 Reset asserted mid-qualification SHALL abort it; after release, qualification restarts from STABLE_LOW.
REQ-023 If switch is held 1 across reset release, the block SHALL report it as a normal 0->1 transition (level rises after the REQ-018 latency, with a rise pulse).

Configuration
REQ-024 Macro SWITCH_DEBOUNCE_TOGGLE_EN SHALL select the light behaviour.
REQ-025 With SWITCH_DEBOUNCE_TOGGLE_EN defined, light SHALL be a registered toggle that inverts on the cycle rise is 1, so each debounced press flips the LED.
REQ-026 Without it, light SHALL equal level, and the toggle flop SHALL not be generated.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-027 Reset, then switch 0->1 clean before edge 1 and held -> level=1 and rise=1 at edge 7; rise=0 at edge 8; fall stays 0.
REQ-028 Switch high for 3 cycles, then low -> level, rise, fall and light stay 0 throughout.
REQ-029 Switch 0->1 with toggles at cycles +2 and +4, then held -> level rises 7 edges after the last toggle; exactly one rise pulse.
REQ-030 Level=1, then switch low and held -> fall=1 and level=0 at edge 7 after the change.
REQ-031 rst_n pulsed low during WAIT_HIGH -> all outputs 0 immediately; with switch held 1, level rises 7 edges after release.
REQ-032 With SWITCH_DEBOUNCE_TOGGLE_EN, two clean presses -> light goes 0->1->0, one change per rise; without it, light tracks level exactly.
